// File: rtl/cram_unload_sequencer.sv
// Streams a contiguous CRAM word range to the swizzle stage; optional zero padding under CRAM_UNLOAD_PAD_EN.
// Latency: start -> first data_valid 3 cycles; hold pauses read issue only; output has no backpressure.
module cram_unload_sequencer #(
  parameter int RAM_DWIDTH   = 40,
  parameter int RAM_AWIDTH   = 9,
  parameter int NUM_WORDS    = 512,
  parameter int SWITCH_COUNT = 40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [RAM_AWIDTH-1:0] base_addr,
  input  logic [RAM_AWIDTH:0]   num_words,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic [RAM_AWIDTH-1:0] ram_addr,
  output logic                  ram_re,
  input  logic [RAM_DWIDTH-1:0] ram_rdata,
  output logic                  data_valid,
  output logic [RAM_DWIDTH-1:0] data_out
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_PAD, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [RAM_AWIDTH-1:0] addr;
  logic [RAM_AWIDTH-1:0] addr_nxt;
  logic [RAM_AWIDTH:0]   remaining;
  logic                  rd_vld;
  logic                  pipe_empty;

  assign addr_nxt = (addr == RAM_AWIDTH'(NUM_WORDS - 1)) ? '0 : addr + 1'b1;

`ifdef CRAM_UNLOAD_PAD_EN
  localparam int SCW = (SWITCH_COUNT > 1) ? $clog2(SWITCH_COUNT) : 1;
  logic           pad_re;
  logic           pad_vld;
  logic [SCW-1:0] sw_cnt;
  logic [SCW-1:0] sw_nxt;

  // sw_cnt tracks total words issued (real + pad) modulo SWITCH_COUNT
  assign sw_nxt     = (sw_cnt == SCW'(SWITCH_COUNT - 1)) ? '0 : sw_cnt + 1'b1;
  assign pipe_empty = !ram_re && !rd_vld && !pad_re && !pad_vld;
`else
  assign pipe_empty = !ram_re && !rd_vld;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      addr      <= '0;
      remaining <= '0;
`ifdef CRAM_UNLOAD_PAD_EN
      pad_re    <= 1'b0;
      sw_cnt    <= '0;
`endif
    end else begin
      ram_re <= 1'b0;
      done   <= 1'b0;
`ifdef CRAM_UNLOAD_PAD_EN
      pad_re <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            addr      <= base_addr;
            remaining <= num_words;
`ifdef CRAM_UNLOAD_PAD_EN
            sw_cnt    <= '0;
`endif
            if (num_words == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (!hold) begin
            ram_re    <= 1'b1;
            ram_addr  <= addr;
            addr      <= addr_nxt;
            remaining <= remaining - 1'b1;
`ifdef CRAM_UNLOAD_PAD_EN
            sw_cnt    <= sw_nxt;
            if (remaining == (RAM_AWIDTH+1)'(1))
              state <= (sw_nxt == '0) ? S_DRAIN : S_PAD;
`else
            if (remaining == (RAM_AWIDTH+1)'(1))
              state <= S_DRAIN;
`endif
          end
        end
`ifdef CRAM_UNLOAD_PAD_EN
        S_PAD: begin
          if (!hold) begin
            pad_re <= 1'b1;
            sw_cnt <= sw_nxt;
            if (sw_nxt == '0)
              state <= S_DRAIN;
          end
        end
`endif
        S_DRAIN: begin
          // leave only once the last issued word has landed on data_out
          if (pipe_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pad slots ride the same two-stage pipe as real reads so ordering is preserved
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld     <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
`ifdef CRAM_UNLOAD_PAD_EN
      pad_vld    <= 1'b0;
`endif
    end else begin
      rd_vld <= ram_re;
`ifdef CRAM_UNLOAD_PAD_EN
      pad_vld    <= pad_re;
      data_valid <= rd_vld || pad_vld;
      if (rd_vld)
        data_out <= ram_rdata;
      else if (pad_vld)
        data_out <= '0;
`else
      data_valid <= rd_vld;
      if (rd_vld)
        data_out <= ram_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_cram_unload_sequencer.sv
// Randomized bench for cram_unload_sequencer with a CRAM model and a word-list reference model.
module tb_cram_unload_sequencer;
  localparam int DW = 40;
  localparam int AW = 9;
  localparam int NW = 512;
  localparam int SC = 40;

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy, done, ram_re, data_valid;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] data_out;

  cram_unload_sequencer #(.RAM_DWIDTH(DW), .RAM_AWIDTH(AW), .NUM_WORDS(NW), .SWITCH_COUNT(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_words(num_words),
    .hold(hold), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .data_valid(data_valid), .data_out(data_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NW];
  always @(posedge clk) if (ram_re) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int start_cyc, done_cnt, done_cyc, busy_cnt, hold_viol;
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] exp_q[$];
  int            vcyc_q[$];
  int            re_cyc_q[$];
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] last_dout = '0;

  always @(negedge clk) begin
    if (data_valid) begin obs_q.push_back(data_out); vcyc_q.push_back(cyc); end
    if (ram_re) begin addr_q.push_back(ram_addr); re_cyc_q.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (reset) last_dout = '0;
    else begin
      if (!data_valid && data_out !== last_dout) hold_viol++;
      if (data_valid) last_dout = data_out;
    end
  end

  // Reference: the words a command must emit, in order
  task automatic build_exp(input int b, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % NW]);
`ifdef CRAM_UNLOAD_PAD_EN
    if (n != 0) while (exp_q.size() % SC != 0) exp_q.push_back('0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete(); vcyc_q.delete(); addr_q.delete(); re_cyc_q.delete();
    done_cnt = 0; busy_cnt = 0; hold_viol = 0; done_cyc = -1;
  endtask

  task automatic issue_start(input int b, input int n);
    base_addr = AW'(b);
    num_words = (AW+1)'(n);
    start = 1'b1;
    start_cyc = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rand_hold, output bit timed_out);
    for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
      hold = rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
    end
    timed_out = (done_cnt == 0);
    hold = 1'b0;
    repeat (3) step();
  endtask

  task automatic run_cmd(input int b, input int n, input bit rand_hold, output bit timed_out);
    clear_obs();
    build_exp(b, n);
    issue_start(b, n);
    wait_done(rand_hold, timed_out);
  endtask

  task automatic test_reset();
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done); end
    checks++; if (ram_re !== 1'b0) begin errors++; $display("FAIL rst_ram_re got %0b exp 0", ram_re); end
    checks++; if (ram_addr !== '0) begin errors++; $display("FAIL rst_ram_addr got %0d exp 0", ram_addr); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got %0b exp 0", data_valid); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL rst_data_out got %h exp 0", data_out); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bit to;
    run_cmd(0, 4, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
    checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL basic_re_count got %0d exp 4", addr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== AW'(i) || re_cyc_q[i] != start_cyc + 1 + i) begin
        errors++; $display("FAIL basic_re[%0d] got addr %0d cyc %0d exp addr %0d cyc %0d", i,
                           (i < addr_q.size()) ? int'(addr_q[i]) : -1, (i < re_cyc_q.size()) ? re_cyc_q[i] : -1, i, start_cyc + 1 + i);
      end
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || vcyc_q[i] != start_cyc + 3 + i) begin
        errors++; $display("FAIL basic_word[%0d] got %h cyc %0d exp %h cyc %0d", i,
                           (i < obs_q.size()) ? obs_q[i] : '0, (i < vcyc_q.size()) ? vcyc_q[i] : -1, exp_q[i], start_cyc + 3 + i);
      end
    end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL basic_word_count got %0d exp 4", obs_q.size()); end
    checks++; if (done_cnt != 1 || done_cyc != start_cyc + 7) begin
      errors++; $display("FAIL basic_done got cnt %0d cyc %0d exp cnt 1 cyc %0d", done_cnt, done_cyc, start_cyc + 7); end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", busy_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b exp 0", busy); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [AW-1:0] ea [4] = '{9'd510, 9'd511, 9'd0, 9'd1};
    run_cmd(510, 4, 1'b0, to);
    checks++; if (to || addr_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d timeout %0b exp 4", addr_q.size(), to); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= addr_q.size() || addr_q[i] !== ea[i] || i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL wrap[%0d] got addr %0d data %h exp addr %0d data %h", i,
                           (i < addr_q.size()) ? int'(addr_q[i]) : -1, (i < obs_q.size()) ? obs_q[i] : '0, ea[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_hold();
    bit to;
    int offs [5] = '{3, 4, 7, 8, 9};
    int b = $urandom_range(0, NW - 1);
    clear_obs();
    build_exp(b, 5);
    issue_start(b, 5);
    step(); step();
    hold = 1'b1;
    step(); step();
    hold = 1'b0;
    wait_done(1'b0, to);
    checks++; if (to || obs_q.size() != 5) begin errors++; $display("FAIL hold_count got %0d timeout %0b exp 5", obs_q.size(), to); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || vcyc_q[i] != start_cyc + offs[i]) begin
        errors++; $display("FAIL hold_word[%0d] got %h cyc %0d exp %h cyc %0d", i,
                           (i < obs_q.size()) ? obs_q[i] : '0, (i < vcyc_q.size()) ? vcyc_q[i] : -1, exp_q[i], start_cyc + offs[i]);
      end
    end
    checks++; if (addr_q.size() != 5) begin errors++; $display("FAIL hold_re_count got %0d exp 5", addr_q.size()); end
  endtask

  task automatic test_zero();
    bit to;
    run_cmd($urandom_range(0, NW - 1), 0, 1'b0, to);
    checks++; if (to || done_cnt != 1) begin errors++; $display("FAIL zero_done got %0d exp 1", done_cnt); end
    checks++; if (busy_cnt != 1) begin errors++; $display("FAIL zero_busy_cycles got %0d exp 1", busy_cnt); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_valid got %0d exp 0", obs_q.size()); end
    checks++; if (addr_q.size() != 0) begin errors++; $display("FAIL zero_ram_re got %0d exp 0", addr_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_obs();
    issue_start($urandom_range(0, NW - 1), 20);
    for (int k = 0; k < 50 && addr_q.size() < 3; k++) step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ram_re !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got busy %0b done %0b re %0b exp 0 0 0", busy, done, ram_re); end
    checks++; if (ram_addr !== '0 || data_valid !== 1'b0 || data_out !== '0) begin
      errors++; $display("FAIL midrst_data got addr %0d vld %0b dout %h exp 0 0 0", ram_addr, data_valid, data_out); end
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_cnt); end
    run_cmd($urandom_range(0, NW - 1), 6, 1'b1, to);
    checks++; if (to || obs_q != exp_q) begin
      errors++; $display("FAIL midrst_restart got %0d words timeout %0b exp %0d words", obs_q.size(), to, exp_q.size()); end
  endtask

  task automatic test_pad();
    bit to;
`ifdef CRAM_UNLOAD_PAD_EN
    int expn = 80;
`else
    int expn = 41;
`endif
    run_cmd($urandom_range(0, NW - 1), 41, 1'b1, to);
    checks++; if (to || obs_q.size() != expn) begin
      errors++; $display("FAIL pad_count got %0d timeout %0b exp %0d", obs_q.size(), to, expn); end
    checks++; if (obs_q != exp_q) begin errors++; $display("FAIL pad_words got %0d words exp %0d matching words", obs_q.size(), exp_q.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL pad_done got %0d exp 1", done_cnt); end
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int t = 0; t < 6; t++) begin
      n = (t == 0) ? NW : $urandom_range(1, 90);
      run_cmd($urandom_range(0, NW - 1), n, 1'b1, to);
      checks++; if (to || obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got %0d timeout %0b exp %0d", t, obs_q.size(), to, exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_word[%0d] got %h exp %h", t, i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
          break;
        end
      end
      checks++; if (done_cnt != 1 || busy !== 1'b0) begin
        errors++; $display("FAIL rand%0d_done got cnt %0d busy %0b exp 1 0", t, done_cnt, busy); end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_dout_hold got %0d changes exp 0", t, hold_viol); end
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = DW'({$urandom, $urandom});
    reset = 1'b0;
    #1 reset = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_zero();
    test_reset_mid();
    test_pad();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
